pipeline_control: RTL and testbench

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipeline_control.sv | 112 +++++++++++
 tb/tb_pipeline_control.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
// Pipeline hazard control: stall/flush steering, halt tracking and performance counters.
module pipeline_control #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_req,
   input  logic             mem_halt,
   input  logic [1:0]       pred,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       ex_wsel,
   input  logic             ex_MemRd,
   output logic             pc_en,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             exec_en,
   output logic             mem_en,
   output logic             fetch_flush,
   output logic             decode_flush,
   output logic             exec_flush,
   output logic             halt,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam logic [1:0] WRONG_PRED = 2'd1;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t state;

   logic dstall;
   logic load_use;
   logic mispred;

   // Hazard decode from the current stage contents
   always_comb begin
      dstall   = mem_req && !dhit;
      load_use = ex_MemRd && (ex_wsel != 5'd0) &&
                 ((ex_wsel == id_rs) || (ex_wsel == id_rt));
      mispred  = (pred == WRONG_PRED);
   end

   // State, halt flag and counters; the transition edge into HALTED still counts as RUN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state       <= RUN;
         halt        <= 1'b0;
         cycle_cnt   <= '0;
         mispred_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               cycle_cnt <= cycle_cnt + CNT_W'(1);
               if (mispred && !dstall) begin
                  mispred_cnt <= mispred_cnt + CNT_W'(1);
               end
               if (mem_halt && !dstall) begin
                  state <= HALTED;
                  halt  <= 1'b1;
               end
            end
            HALTED: begin
               state <= HALTED;
               halt  <= 1'b1;
            end
            default: begin
               state <= RUN;
               halt  <= 1'b0;
            end
         endcase
      end
   end

   // Latch enables and bubble injection in priority order: halted, dstall, mispredict, load-use, ifetch miss
   always_comb begin
      pc_en        = 1'b0;
      fetch_en     = 1'b0;
      decode_en    = 1'b0;
      exec_en      = 1'b0;
      mem_en       = 1'b0;
      fetch_flush  = 1'b0;
      decode_flush = 1'b0;
      exec_flush   = 1'b0;
      if (state == RUN && !dstall) begin
         pc_en     = 1'b1;
         fetch_en  = 1'b1;
         decode_en = 1'b1;
         exec_en   = 1'b1;
         mem_en    = 1'b1;
         if (mispred) begin
            fetch_flush  = 1'b1;
            decode_flush = 1'b1;
            exec_flush   = 1'b1;
         end else if (load_use) begin
            pc_en        = 1'b0;
            fetch_en     = 1'b0;
            decode_flush = 1'b1;
         end else if (!ihit) begin
            pc_en       = 1'b0;
            fetch_flush = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control against a rule-level reference model.
module tb_pipeline_control;

   localparam int unsigned CNT_W = 32;

   logic             CLK = 1'b0;
   logic             nRST = 1'b0;
   logic             ihit, dhit, mem_req, mem_halt, ex_MemRd;
   logic [1:0]       pred;
   logic [4:0]       id_rs, id_rt, ex_wsel;
   logic             pc_en, fetch_en, decode_en, exec_en, mem_en;
   logic             fetch_flush, decode_flush, exec_flush, halt;
   logic [CNT_W-1:0] cycle_cnt, mispred_cnt;

   logic [7:0] ctrl;
   assign ctrl = {pc_en, fetch_en, decode_en, exec_en, mem_en,
                  fetch_flush, decode_flush, exec_flush};

   // Model state
   bit               m_halted;
   logic [CNT_W-1:0] m_cyc, m_mis;

   int total = 0;
   int bad   = 0;

   pipeline_control #(.CNT_W(CNT_W)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
      .mem_halt(mem_halt), .pred(pred), .id_rs(id_rs), .id_rt(id_rt),
      .ex_wsel(ex_wsel), .ex_MemRd(ex_MemRd), .pc_en(pc_en), .fetch_en(fetch_en),
      .decode_en(decode_en), .exec_en(exec_en), .mem_en(mem_en),
      .fetch_flush(fetch_flush), .decode_flush(decode_flush), .exec_flush(exec_flush),
      .halt(halt), .cycle_cnt(cycle_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 CLK = ~CLK;

   // Expected {pc,fetch,decode,exec,mem enables, fetch,decode,exec flushes}
   function automatic logic [7:0] exp_ctrl();
      bit ds, lu;
      ds = mem_req && !dhit;
      lu = ex_MemRd && (ex_wsel != 0) && (ex_wsel == id_rs || ex_wsel == id_rt);
      if (m_halted || ds)   return 8'b00000_000;
      if (pred == 2'd1)     return 8'b11111_111;
      if (lu)               return 8'b00111_010;
      if (!ihit)            return 8'b01111_100;
      return 8'b11111_000;
   endfunction

   task automatic set_idle();
      ihit = 1; dhit = 1; mem_req = 0; mem_halt = 0; pred = 2'd2;
      id_rs = 0; id_rt = 0; ex_wsel = 0; ex_MemRd = 0;
   endtask

   // Advance one clock edge, updating the model from the inputs present at that edge
   task automatic tick();
      bit ds;
      ds = mem_req && !dhit;
      if (!m_halted) begin
         m_cyc = m_cyc + 1;
         if (pred == 2'd1 && !ds) m_mis = m_mis + 1;
         if (mem_halt && !ds) m_halted = 1;
      end
      @(posedge CLK);
      #1;
   endtask

   // Pulse reset between edges
   task automatic pulse_reset();
      @(negedge CLK);
      nRST = 0;
      #2;
      nRST = 1;
      m_halted = 0; m_cyc = '0; m_mis = '0;
   endtask

   task automatic test_reset();
      set_idle();
      nRST = 0;
      #2;
      total++;
      if (halt !== 1'b0 || cycle_cnt !== '0 || mispred_cnt !== '0) begin
         bad++;
         $display("FAIL reset_state: halt=%b cyc=%0d mis=%0d required 0/0/0", halt, cycle_cnt, mispred_cnt);
      end
      @(negedge CLK);
      nRST = 1;
      m_halted = 0; m_cyc = '0; m_mis = '0;
   endtask

   task automatic test_run_basic();
      pulse_reset();
      set_idle();
      for (int i = 0; i < 10; i++) begin
         total++;
         if (ctrl !== 8'b11111_000) begin
            bad++;
            $display("FAIL run_ctrl cyc%0d: got %b required 11111000", i, ctrl);
         end
         tick();
      end
      total++;
      if (cycle_cnt !== 32'd10) begin
         bad++;
         $display("FAIL run_cycle_cnt: got %0d required 10", cycle_cnt);
      end
   endtask

   task automatic test_load_use();
      set_idle();
      ex_MemRd = 1; ex_wsel = 5; id_rt = 5; id_rs = 9;
      #1;
      total++;
      if (ctrl !== 8'b00111_010) begin
         bad++;
         $display("FAIL load_use: got %b required 00111010", ctrl);
      end
      tick();
      ex_wsel = 0; id_rt = 0; id_rs = 0;
      #1;
      total++;
      if (ctrl !== 8'b11111_000) begin
         bad++;
         $display("FAIL load_use_r0: got %b required 11111000", ctrl);
      end
      tick();
      set_idle();
      ihit = 0;
      #1;
      total++;
      if (ctrl !== 8'b01111_100) begin
         bad++;
         $display("FAIL ifetch_miss: got %b required 01111100", ctrl);
      end
      tick();
      set_idle();
   endtask

   task automatic test_dstall_mispred();
      logic [CNT_W-1:0] mis0;
      set_idle();
      mis0 = m_mis;
      mem_req = 1; dhit = 0; pred = 2'd1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (ctrl !== 8'b00000_000) begin
            bad++;
            $display("FAIL dstall_freeze cyc%0d: got %b required 00000000", i, ctrl);
         end
         tick();
      end
      total++;
      if (mispred_cnt !== mis0) begin
         bad++;
         $display("FAIL dstall_no_count: got %0d required %0d", mispred_cnt, mis0);
      end
      dhit = 1;
      #1;
      total++;
      if (ctrl !== 8'b11111_111) begin
         bad++;
         $display("FAIL dstall_release: got %b required 11111111", ctrl);
      end
      tick();
      set_idle();
      tick();
      total++;
      if (mispred_cnt !== mis0 + 1) begin
         bad++;
         $display("FAIL mispred_once: got %0d required %0d", mispred_cnt, mis0 + 1);
      end
   endtask

   task automatic test_priority();
      set_idle();
      pred = 2'd1; ihit = 0; ex_MemRd = 1; ex_wsel = 3; id_rs = 3;
      #1;
      total++;
      if (ctrl !== 8'b11111_111) begin
         bad++;
         $display("FAIL mispred_priority: got %b required 11111111", ctrl);
      end
      tick();
      pred = 2'd3;
      #1;
      total++;
      if (ctrl !== 8'b00111_010) begin
         bad++;
         $display("FAIL pred3_as_na: got %b required 00111010", ctrl);
      end
      tick();
      set_idle();
   endtask

   task automatic test_halt();
      pulse_reset();
      set_idle();
      for (int i = 0; i < 7; i++) tick();
      total++;
      if (cycle_cnt !== 32'd7) begin
         bad++;
         $display("FAIL pre_halt_cnt: got %0d required 7", cycle_cnt);
      end
      mem_halt = 1;
      tick();
      set_idle();
      total++;
      if (halt !== 1'b1 || cycle_cnt !== 32'd8) begin
         bad++;
         $display("FAIL halt_entry: halt=%b cyc=%0d required 1/8", halt, cycle_cnt);
      end
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if (ctrl !== 8'b00000_000 || cycle_cnt !== 32'd8 || halt !== 1'b1) begin
            bad++;
            $display("FAIL halted_hold cyc%0d: ctrl=%b cyc=%0d halt=%b required 00000000/8/1", i, ctrl, cycle_cnt, halt);
         end
         tick();
      end
      // Reset while halted, mid-cycle
      @(negedge CLK);
      #2;
      nRST = 0;
      #1;
      total++;
      if (halt !== 1'b0 || cycle_cnt !== '0 || mispred_cnt !== '0) begin
         bad++;
         $display("FAIL reset_in_halt: halt=%b cyc=%0d mis=%0d required 0/0/0", halt, cycle_cnt, mispred_cnt);
      end
      nRST = 1;
      m_halted = 0; m_cyc = '0; m_mis = '0;
      tick();
      total++;
      if (halt !== 1'b0 || cycle_cnt !== 32'd1 || ctrl !== 8'b11111_000) begin
         bad++;
         $display("FAIL resume_after_reset: halt=%b cyc=%0d ctrl=%b required 0/1/11111000", halt, cycle_cnt, ctrl);
      end
   endtask

   task automatic test_halt_with_mispred();
      pulse_reset();
      set_idle();
      tick();
      mem_halt = 1; pred = 2'd1;
      #1;
      total++;
      if (ctrl !== 8'b11111_111) begin
         bad++;
         $display("FAIL halt_mispred_ctrl: got %b required 11111111", ctrl);
      end
      tick();
      set_idle();
      total++;
      if (halt !== 1'b1 || mispred_cnt !== 32'd1 || cycle_cnt !== 32'd2) begin
         bad++;
         $display("FAIL halt_mispred_state: halt=%b mis=%0d cyc=%0d required 1/1/2", halt, mispred_cnt, cycle_cnt);
      end
   endtask

   task automatic test_random();
      pulse_reset();
      for (int i = 0; i < 600; i++) begin
         ihit     = 1'($urandom_range(0, 3) != 0);
         mem_req  = 1'($urandom_range(0, 1));
         dhit     = 1'($urandom_range(0, 2) != 0);
         mem_halt = 1'($urandom_range(0, 39) == 0);
         pred     = 2'($urandom_range(0, 3));
         ex_MemRd = 1'($urandom_range(0, 1));
         ex_wsel  = 5'($urandom_range(0, 3));
         id_rs    = 5'($urandom_range(0, 3));
         id_rt    = 5'($urandom_range(0, 3));
         #1;
         total++;
         if (ctrl !== exp_ctrl()) begin
            bad++;
            $display("FAIL rand_ctrl i=%0d: got %b required %b", i, ctrl, exp_ctrl());
         end
         tick();
         total++;
         if (halt !== 1'(m_halted) || cycle_cnt !== m_cyc || mispred_cnt !== m_mis) begin
            bad++;
            $display("FAIL rand_state i=%0d: halt=%b cyc=%0d mis=%0d required %b/%0d/%0d",
                     i, halt, cycle_cnt, mispred_cnt, m_halted, m_cyc, m_mis);
         end
         if (m_halted && $urandom_range(0, 7) == 0) pulse_reset();
      end
      set_idle();
   endtask

   initial begin
      m_halted = 0; m_cyc = '0; m_mis = '0;
      test_reset();
      test_run_basic();
      test_load_use();
      test_dstall_mispred();
      test_priority();
      test_halt();
      test_halt_with_mispred();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
